// File: rtl/screen_pkg.sv
// Shared types and constants for the game screen sequencer: screen states,
// the screen codes seen by the background/sprite mux, and default keycodes.
package screen_pkg;

    typedef enum logic [2:0] {
        TITLE,
        GAME,
        VICTORY,
        DEFEAT,
        PAUSE
    } screen_state_t;

    localparam int SCR_CODE_TITLE   = 0;
    localparam int SCR_CODE_GAME    = 1;
    localparam int SCR_CODE_VICTORY = 2;
    localparam int SCR_CODE_DEFEAT  = 3;
    localparam int SCR_CODE_PAUSE   = 4;

    localparam logic [7:0] KEY_START_DEFAULT = 8'h2C;
    localparam logic [7:0] KEY_PAUSE_DEFAULT = 8'h29;

endpackage

// File: rtl/screen_tick_gen.sv
// Free-running clock-enable generator: tick is high one Clk cycle in every
// TICK_DIV, and every cycle when TICK_DIV is 1.
module screen_tick_gen #(
    parameter int TICK_DIV = 16
) (
    input  logic Clk,
    input  logic Reset_n,
    output logic tick
);

    localparam int            TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/screen_sequencer.sv
// Game screen sequencer: title / game / pause / victory / defeat selection.
// Define SCREEN_AUTO_RETURN_EN for timed (or start-key) return from end screens.
module screen_sequencer
    import screen_pkg::*;
#(
    parameter int         CODE_W        = 8,
    parameter logic [7:0] KEY_START     = KEY_START_DEFAULT,
    parameter logic [7:0] KEY_PAUSE     = KEY_PAUSE_DEFAULT,
    parameter int         TICK_DIV      = 16,
    parameter int         CONFIRM_TICKS = 11,
    parameter int         HOLD_TICKS    = 64
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              VICTORY_sig,
    input  logic              DEFEAT_sig,
    input  logic [7:0]        keycode,
    output logic [CODE_W-1:0] screen_code,
    output logic              game_active,
    output logic              screen_changed
);

    if (TICK_DIV < 1 || CONFIRM_TICKS < 1 || HOLD_TICKS < 1) begin : g_bad_params
        $error("screen_sequencer: TICK_DIV, CONFIRM_TICKS and HOLD_TICKS must be >= 1");
    end

    localparam int            CW        = $clog2(CONFIRM_TICKS + 1);
    localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_TICKS - 1);
    localparam logic [CW-1:0] CONF_MAX  = CW'(CONFIRM_TICKS);

    logic          tick;
    logic [7:0]    key_prev_q;
    screen_state_t state_q, state_d, state_prev_q;
    logic          changed_q;
    logic [CW-1:0] vic_cnt_q, vic_cnt_d;
    logic [CW-1:0] def_cnt_q, def_cnt_d;
    logic          press_start, press_pause;
    logic          vic_conf, def_conf;
    logic          cnt_keep, cnt_update;

    screen_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .tick   (tick)
    );

    assign press_start = (keycode == KEY_START) && (key_prev_q != KEY_START);
    assign press_pause = (keycode == KEY_PAUSE) && (key_prev_q != KEY_PAUSE);
    assign vic_conf    = tick && VICTORY_sig && (vic_cnt_q == CONF_LAST);
    assign def_conf    = tick && DEFEAT_sig  && (def_cnt_q == CONF_LAST);

`ifdef SCREEN_AUTO_RETURN_EN
    localparam int            HW        = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          hold_done;

    assign hold_done = tick && (hold_cnt_q == HOLD_LAST);

    // Counts ticks spent in an end screen; restarts from zero on every entry.
    always_comb begin
        hold_cnt_d = hold_cnt_q;
        if (state_d != state_q || !(state_q == VICTORY || state_q == DEFEAT)) begin
            hold_cnt_d = '0;
        end else if (tick) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_cnt_q <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
        end
    end
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= TITLE;
            state_prev_q <= TITLE;
            changed_q    <= 1'b0;
            key_prev_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            state_prev_q <= state_q;
            changed_q    <= (state_q != state_prev_q);
            key_prev_q   <= keycode;
        end
    end

    // Key presses win over results; DEFEAT wins over VICTORY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            TITLE: begin
                if (press_start) state_d = GAME;
            end
            GAME: begin
                if (press_pause)   state_d = PAUSE;
                else if (def_conf) state_d = DEFEAT;
                else if (vic_conf) state_d = VICTORY;
            end
            PAUSE: begin
                if (press_pause || press_start) state_d = GAME;
            end
            VICTORY, DEFEAT: begin
`ifdef SCREEN_AUTO_RETURN_EN
                if (press_start || hold_done) state_d = TITLE;
`endif
            end
            default: state_d = TITLE;
        endcase
    end

    // Counters survive GAME<->PAUSE (frozen while paused) and clear otherwise.
    assign cnt_keep   = (state_d == GAME) || (state_d == PAUSE);
    assign cnt_update = tick && (state_q == GAME) && (state_d == GAME);

    always_comb begin
        vic_cnt_d = vic_cnt_q;
        def_cnt_d = def_cnt_q;
        if (!cnt_keep) begin
            vic_cnt_d = '0;
            def_cnt_d = '0;
        end else if (cnt_update) begin
            vic_cnt_d = !VICTORY_sig ? '0 : (vic_cnt_q == CONF_MAX) ? CONF_MAX : vic_cnt_q + 1'b1;
            def_cnt_d = !DEFEAT_sig  ? '0 : (def_cnt_q == CONF_MAX) ? CONF_MAX : def_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vic_cnt_q <= '0;
            def_cnt_q <= '0;
        end else begin
            vic_cnt_q <= vic_cnt_d;
            def_cnt_q <= def_cnt_d;
        end
    end

    always_comb begin
        screen_code = CODE_W'(SCR_CODE_TITLE);
        case (state_q)
            TITLE:   screen_code = CODE_W'(SCR_CODE_TITLE);
            GAME:    screen_code = CODE_W'(SCR_CODE_GAME);
            VICTORY: screen_code = CODE_W'(SCR_CODE_VICTORY);
            DEFEAT:  screen_code = CODE_W'(SCR_CODE_DEFEAT);
            PAUSE:   screen_code = CODE_W'(SCR_CODE_PAUSE);
            default: screen_code = CODE_W'(SCR_CODE_TITLE);
        endcase
        game_active = (state_q == GAME);
    end

    assign screen_changed = changed_q;

endmodule
